// File: rtl/rf_write_queue.sv
// Register-file write queue: FIFO of pending {addr,data} writes, drained one per cycle,
// with combinational forwarding of the youngest pending write to two read ports.
module rf_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_addr,
  input  logic [31:0]                in_data,
  output logic [4:0]                 WriteAddress,
  output logic [31:0]                WriteData,
  output logic                       ReadWriteEn,
  input  logic [4:0]                 ReadAddress1,
  input  logic [4:0]                 ReadAddress2,
  output logic                       Fwd1Hit,
  output logic                       Fwd2Hit,
  output logic [31:0]                Fwd1Data,
  output logic [31:0]                Fwd2Data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  assign in_ready = (count_q < CW'(DEPTH));
  // Writes to r0 finish the handshake but never occupy a slot.
  assign push     = in_valid && in_ready && (in_addr != 5'd0);
  assign pop      = (count_q != '0);
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        addr_mem[tail] <= in_addr;
        data_mem[tail] <= in_data;
        tail           <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign ReadWriteEn  = pop;
  assign WriteAddress = pop ? addr_mem[head] : 5'd0;
  assign WriteData    = pop ? data_mem[head] : 32'd0;

  // Scan oldest to youngest so the last match seen is the newest pending write.
  always_comb begin
    logic [AW-1:0] idx;
    idx      = '0;
    Fwd1Hit  = 1'b0;
    Fwd2Hit  = 1'b0;
    Fwd1Data = 32'd0;
    Fwd2Data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (CW'(i) < count_q) begin
        if (ReadAddress1 != 5'd0 && addr_mem[idx] == ReadAddress1) begin
          Fwd1Hit  = 1'b1;
          Fwd1Data = data_mem[idx];
        end
        if (ReadAddress2 != 5'd0 && addr_mem[idx] == ReadAddress2) begin
          Fwd2Hit  = 1'b1;
          Fwd2Data = data_mem[idx];
        end
      end
    end
  end
endmodule
